// File: rtl/fixed_point_div_pkg.sv
// Shared definitions for the fixed-point signed long divider and its operand loader.
package fixed_point_div_pkg;

  // Default operand format: Q4.4 signed, shared with the divider core.
  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 4;

  // Operand loader FSM states.
  typedef enum logic [1:0] {
    S_DIVIDEND = 2'd0,
    S_DIVISOR  = 2'd1,
    S_OUT      = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_abs.sv
// Combinational two's-complement magnitude and sign extraction.
// The most-negative code maps onto itself, which is the correct unsigned magnitude.
module fixed_point_abs #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] mag,
  output logic              sign
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  assign sign = x[DATA_W-1];

  // Negate negative inputs, pass non-negative inputs through unchanged.
  always_comb begin
    mag = x;
    if (sign) begin
      mag = (~x) + ONE;
    end
  end

endmodule

// File: rtl/fixed_point_div_operand_loader.sv
// Byte-serial operand loader for the fixed-point signed divider.
// Collects a dividend/divisor pair, converts it to magnitudes plus result-sign and
// divide-by-zero flags, and holds the pair on a valid/ready handshake until consumed.
module fixed_point_div_operand_loader
  import fixed_point_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_first,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_dividend_mag,
  output logic [DATA_W-1:0] o_divisor_mag,
  output logic              o_neg_result,
  output logic              o_div_by_zero,
  output logic              o_valid,
  input  logic              i_ready
);

  // FRAC_W only documents where the binary point sits; the loader never shifts.
  if (FRAC_W > DATA_W) begin : g_frac_w_unused
  end

  state_t            state_reg;
  state_t            state_next;
  logic              capture_dividend;
  logic              capture_divisor;
  logic [DATA_W-1:0] dividend_reg;

  logic [DATA_W-1:0] dividend_mag;
  logic [DATA_W-1:0] divisor_mag;
  logic              dividend_sign;
  logic              divisor_sign;
  logic              dividend_zero;
  logic              divisor_zero;

  // The held dividend and the divisor byte on the bus are converted in parallel, so the
  // whole output pair can load on the divisor-accept edge.
  fixed_point_abs #(.DATA_W(DATA_W)) u_abs_dividend (
    .x    (dividend_reg),
    .mag  (dividend_mag),
    .sign (dividend_sign)
  );

  fixed_point_abs #(.DATA_W(DATA_W)) u_abs_divisor (
    .x    (i_data),
    .mag  (divisor_mag),
    .sign (divisor_sign)
  );

  assign dividend_zero = (dividend_reg == '0);
  assign divisor_zero  = (i_data == '0);

  // Ready is a pure decode of the registered state: no path from i_ready.
  assign o_ready = (state_reg != S_OUT);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= S_DIVIDEND;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and capture strobes.
  always_comb begin
    state_next       = state_reg;
    capture_dividend = 1'b0;
    capture_divisor  = 1'b0;
    case (state_reg)
      S_DIVIDEND: begin
        // Non-first bytes are dropped while waiting for the start of a pair.
        if (i_valid && i_first) begin
          capture_dividend = 1'b1;
          state_next       = S_DIVISOR;
        end
      end
      S_DIVISOR: begin
        if (i_valid) begin
          if (i_first) begin
            // A new first byte restarts the pair with a fresh dividend.
            capture_dividend = 1'b1;
          end else begin
            capture_divisor = 1'b1;
            state_next      = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (i_ready) begin
          state_next = S_DIVIDEND;
        end
      end
      default: state_next = S_DIVIDEND;
    endcase
  end

  // Raw dividend holding register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dividend_reg <= '0;
    end else if (capture_dividend) begin
      dividend_reg <= i_data;
    end
  end

  // Output pair: all fields load together when the divisor is accepted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dividend_mag <= '0;
      o_divisor_mag  <= '0;
      o_neg_result   <= 1'b0;
      o_div_by_zero  <= 1'b0;
    end else if (capture_divisor) begin
      o_dividend_mag <= dividend_mag;
      o_divisor_mag  <= divisor_mag;
      o_neg_result   <= (dividend_sign ^ divisor_sign) && !dividend_zero && !divisor_zero;
      o_div_by_zero  <= divisor_zero;
    end
  end

  // Output valid: raised with the pair, dropped when the divider takes it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
    end else if (capture_divisor) begin
      o_valid <= 1'b1;
    end else if ((state_reg == S_OUT) && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_div_operand_loader.sv
// Self-checking bench for the divider operand loader: directed scenarios plus randomized pairs.
module tb_fixed_point_div_operand_loader;

  logic       i_clk;
  logic       i_reset_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_first;
  logic       o_ready;
  logic [7:0] o_dividend_mag;
  logic [7:0] o_divisor_mag;
  logic       o_neg_result;
  logic       o_div_by_zero;
  logic       o_valid;
  logic       i_ready;

  int n_cmp;
  int n_fail;

  fixed_point_div_operand_loader #(.DATA_W(8), .FRAC_W(4)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .i_first        (i_first),
    .o_ready        (o_ready),
    .o_dividend_mag (o_dividend_mag),
    .o_divisor_mag  (o_divisor_mag),
    .o_neg_result   (o_neg_result),
    .o_div_by_zero  (o_div_by_zero),
    .o_valid        (o_valid),
    .i_ready        (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Observed pair packed as {dividend_mag, divisor_mag, neg_result, div_by_zero}.
  wire [17:0] obs = {o_dividend_mag, o_divisor_mag, o_neg_result, o_div_by_zero};

  // Reference model from signed arithmetic: |a|, |b|, sign of a/b, b==0.
  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ma, mb;
    logic neg, dbz;
    sa  = $signed(a);
    sb  = $signed(b);
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    dbz = (sb == 0);
    neg = (sa != 0) && (sb != 0) && ((sa < 0) != (sb < 0));
    return {ma[7:0], mb[7:0], neg, dbz};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    i_valid = 1'b1;
    i_data  = d;
    i_first = f;
    tick();
    i_valid = 1'b0;
    i_first = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_valid   = 1'b1;
    i_first   = 1'b1;
    i_data    = 8'h5A;
    i_ready   = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({obs, o_valid} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b want 0/0", obs, o_valid);
    end
    i_valid   = 1'b0;
    i_first   = 1'b0;
    i_reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({o_ready, o_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: ready/valid got %b%b want 10", o_ready, o_valid);
    end
    $display("reset: outputs=%h ready=%b valid=%b", obs, o_ready, o_valid);
  endtask

  // Send one pair, check latency and contents, then hand it off.
  task automatic run_pair(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [17:0] exp;
    exp = model(a, b);
    send(a, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_early: valid/ready got %b%b want 01", name, o_valid, o_ready);
    end
    send(b, 1'b0);
    n_cmp++;
    if ({obs, o_valid, o_ready} !== {exp, 2'b10}) begin
      n_fail++;
      $display("FAIL %s_pair: got %h v%b r%b want %h v1 r0", name, obs, o_valid, o_ready, exp);
    end
    $display("%s: a=%h b=%h -> %h valid=%b", name, a, b, obs, o_valid);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s_handoff: valid/ready got %b%b want 01", name, o_valid, o_ready);
    end
  endtask

  task automatic test_basic();
    run_pair("basic", 8'hE8, 8'h20);
    n_cmp++;
    if (model(8'hE8, 8'h20) !== {8'h18, 8'h20, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_model: got %h want %h", model(8'hE8, 8'h20), {8'h18, 8'h20, 2'b10});
    end
  endtask

  task automatic test_zero_div();
    run_pair("zero_div", 8'h30, 8'h00);
    run_pair("zero_div_neg", 8'hC0, 8'h00);
  endtask

  task automatic test_extremes();
    run_pair("most_neg", 8'h80, 8'hFF);
    run_pair("zero_dividend", 8'h00, 8'hF0);
    run_pair("neg_neg", 8'h80, 8'h80);
  endtask

  task automatic test_resync_stall();
    logic [17:0] exp;
    exp = model(8'h20, 8'h40);
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    send(8'h40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_first = i[0];
      i_data  = 8'(8'h91 + i);
      tick();
      n_cmp++;
      if ({obs, o_valid, o_ready} !== {exp, 2'b10}) begin
        n_fail++;
        $display("FAIL stall_%0d: got %h v%b r%b want %h v1 r0", i, obs, o_valid, o_ready, exp);
      end
    end
    $display("resync_stall: held %h valid=%b ready=%b", obs, o_valid, o_ready);
    // Ready and valid together in S_OUT: the handoff wins, the byte is not taken.
    i_ready = 1'b1;
    i_first = 1'b1;
    tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    i_first = 1'b0;
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: valid/ready got %b%b want 01", o_valid, o_ready);
    end
    // If the byte had been taken as a dividend, this non-first byte would complete a pair.
    send(8'h33, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_byte_taken: valid got %b want 0", o_valid);
    end
  endtask

  task automatic test_async_reset();
    send(8'h12, 1'b1);
    send(8'hF4, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: valid got %b want 1", o_valid);
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs, o_valid, o_ready} !== {18'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL async_reset: got %h v%b r%b want 0 v0 r1", obs, o_valid, o_ready);
    end
    tick();
    i_reset_n = 1'b1;
    tick();
    send(8'h05, 1'b0);
    send(8'h07, 1'b0);
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL async_drop: valid/ready got %b%b want 01", o_valid, o_ready);
    end
    $display("async_reset: valid=%b ready=%b", o_valid, o_ready);
    run_pair("after_reset", 8'h7F, 8'h81);
  endtask

  task automatic test_random();
    logic [7:0]  a, b, junk;
    logic [17:0] exp;
    int          stall;
    for (int t = 0; t < 24; t++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        send(junk, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        send(junk, 1'b1);
      end
      send(a, 1'b1);
      if ($urandom_range(0, 1) == 0) tick();
      send(b, 1'b0);
      exp   = model(a, b);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        n_cmp++;
        if ({obs, o_valid} !== {exp, 1'b1}) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d: a=%h b=%h got %h v%b want %h v1", t, s, a, b, obs, o_valid, exp);
        end
        if (s < stall) begin
          i_valid = 1'($urandom);
          i_first = 1'($urandom);
          i_data  = 8'($urandom);
          tick();
          i_valid = 1'b0;
        end
      end
      $display("rand_%0d: a=%h b=%h -> %h stall=%0d", t, a, b, obs, stall);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      n_cmp++;
      if ({o_valid, o_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL rand_%0d_handoff: valid/ready got %b%b want 01", t, o_valid, o_ready);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    i_reset_n = 1'b0;
    i_data    = 8'h00;
    i_valid   = 1'b0;
    i_first   = 1'b0;
    i_ready   = 1'b0;
    test_reset();
    test_basic();
    test_zero_div();
    test_extremes();
    test_resync_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_div_operand_loader.md
# fixed_point_div_operand_loader

Upstream operand stage for the fixed-point signed long divider. Accepts a byte-serial stream of signed Q(DATA_W-FRAC_W).FRAC_W operands, dividend first and divisor second. Converts each pair into unsigned magnitudes, a result-sign flag and a divide-by-zero flag, and presents them to the divider core over a valid/ready handshake. Holds one operand pair at a time; the divider consumes magnitudes and re-applies the sign itself.

## Interface
- DATA_W, 8, operand width in bits (two's complement)
- FRAC_W, 4, fractional bits (informational; no arithmetic depends on it)
- i_clk  input  1  rising-edge clock
- i_reset_n  input  1  asynchronous active-low reset
- i_data  input  DATA_W  signed operand byte
- i_valid  input  1  i_data valid
- i_first  input  1  qualifies i_data as a dividend (start of pair)
- o_ready  output  1  loader accepts i_data this cycle
- o_dividend_mag  output  DATA_W  |dividend|, unsigned
- o_divisor_mag  output  DATA_W  |divisor|, unsigned
- o_neg_result  output  1  quotient must be negated
- o_div_by_zero  output  1  divisor was zero
- o_valid  output  1  output pair valid
- i_ready  input  1  divider accepts pair

## Operation
- FSM states: S_DIVIDEND, S_DIVISOR, S_OUT. Reset state S_DIVIDEND.
- o_ready = 1 in S_DIVIDEND and S_DIVISOR, 0 in S_OUT (registered state decode, no combinational path from i_ready).
- S_DIVIDEND: on i_valid && i_first, capture dividend, go S_DIVISOR. i_valid with i_first=0 is dropped, with o_ready still 1 and the state unchanged.
- S_DIVISOR: on i_valid && !i_first, capture divisor, compute outputs, go S_OUT. On i_valid && i_first, the byte replaces the held dividend (resync) and the state stays S_DIVISOR.
- S_OUT: o_valid=1, outputs stable. On i_ready, go S_DIVIDEND and clear o_valid.
- Magnitude: x >= 0 -> x; x < 0 -> (~x)+1 taken as unsigned DATA_W. The most-negative input (8'h80) yields 8'h80 (128). There is no overflow flag.
- o_div_by_zero = (divisor == 0). o_divisor_mag is then 0.
- o_neg_result = sign(dividend) XOR sign(divisor). It is forced to 0 when the dividend is 0 or o_div_by_zero=1.
- All output registers load together on the divisor-accept edge.

## Timing
- Reset (async assert, sync-free deassert) clears all outputs to 0 and sets state to S_DIVIDEND, so o_ready=1 on the first cycle after reset.
- Latency: dividend accepted at edge N, divisor at edge N+1 earliest. o_valid is high after edge N+2 — wait, no: after edge N+1, i.e. it is visible in the cycle following the divisor accept.
- Throughput: at most one pair per 3 cycles (dividend, divisor, handoff).
- Backpressure: o_valid stays high with outputs unchanged for as long as i_ready=0. i_data is ignored in S_OUT.
- Reset mid-operation discards any partial or pending pair. No o_valid pulse follows.
- i_valid and i_ready both high in S_OUT: i_ready wins and the input byte is not accepted (o_ready=0).

## Structure
- Shared package/include fixed_point_div_pkg holds:
  - state encodings S_DIVIDEND=2'd0, S_DIVISOR=2'd1, S_OUT=2'd2;
  - DATA_W/FRAC_W defaults, shared with the divider core.
- One sub-module, fixed_point_abs (parameter DATA_W). It is combinational and outputs magnitude and sign bit. It is instantiated twice, once each for dividend and divisor.

## Test plan
- Reset: hold i_reset_n=0 with i_valid=1 -> all outputs 0. After release, o_ready=1 and o_valid=0.
- Basic pair: dividend 8'hE8 (-1.5, first) then divisor 8'h20 (2.0) -> o_dividend_mag=8'h18, o_divisor_mag=8'h20, o_neg_result=1, o_div_by_zero=0. o_valid rises in the cycle after the divisor accept.
- Zero divisor: 8'h30 then 8'h00 -> o_div_by_zero=1, o_divisor_mag=0, o_neg_result=0.
- Extremes: 8'h80 then 8'hFF -> mags 8'h80 and 8'h01, o_neg_result=0. Also 8'h00 then 8'hF0 -> o_neg_result=0.
- Resync and stall: 8'h10(first), 8'h20(first), 8'h40 -> dividend_mag=8'h20, divisor_mag=8'h40. Hold i_ready=0 for 5 cycles -> outputs stable and o_ready=0. Then i_ready=1 for one cycle -> o_valid=0 and o_ready=1.
- Async reset asserted while in S_OUT -> o_valid=0 immediately, without waiting for a clock edge. A non-first byte sent after release is dropped.
